br_lite_ni: RTL and testbench
=============================

Name: br_lite_ni

Overview:
- Network interface between a processing element (PE) and a BrLite router's local port.
- TX path: takes PE broadcast/target requests over valid/ready, stamps source address and sequence id, and injects the flit into the router's local input using the req/ack 4-phase handshake.
- RX path: accepts flits the router delivers on its local output, acknowledges them with the matching 4-phase handshake, and buffers them in a FIFO that the PE drains.

Parameters:
- ADDRESS, 16'h0000, this PE's 16-bit address; stamped into every outgoing flit's source field.
- RX_FIFO_DEPTH, 4, RX buffer entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- local_busy_i  in  1  router local_busy_o; high while a previous local injection is not yet cleared
- tx_valid_i  in  1  PE request valid
- tx_ready_o  out  1  NI can accept a request
- tx_service_i  in  br_svc_t  BR_SVC_ALL or BR_SVC_TGT
- tx_target_i  in  16  target address (ignored by the router for ALL)
- tx_payload_i  in  br_payload_t  payload
- flit_o  out  br_data_t  to router flit_i[BR_LOCAL]
- req_o  out  1  to router req_i[BR_LOCAL]
- ack_i  in  1  from router ack_o[BR_LOCAL]
- flit_i  in  br_data_t  from router flit_o[BR_LOCAL]
- req_i  in  1  from router req_o[BR_LOCAL]
- ack_o  out  1  to router ack_i[BR_LOCAL]
- rx_valid_o  out  1  RX FIFO non-empty
- rx_ready_i  in  1  PE pops head
- rx_data_o  out  br_data_t  RX FIFO head

Behaviour:
- Reset values: req_o=0, ack_o=0, rx_valid_o=0, flit_o='0, id counter=0, FIFO empty, both FSMs idle.
- TX FSM states: TX_IDLE, TX_REQ, TX_RELEASE.
  - TX_IDLE: tx_ready_o = !local_busy_i.
  - On tx_valid_i && tx_ready_o with service ALL/TGT: register flit_o = {source=ADDRESS, target, service, payload, id=id_cnt}; id_cnt += 1 (wraps modulo id field width); go to TX_REQ.
  - CLEAR or any other service from the PE: consumed (ready high), discarded, id_cnt unchanged, stay in TX_IDLE.
  - TX_REQ: req_o=1; flit_o held stable. On ack_i=1, go to TX_RELEASE; req_o drops in the next cycle.
  - TX_RELEASE: req_o=0; on ack_i=0, go to TX_IDLE. A one-cycle ack from an ignored or duplicate flit satisfies this immediately.
  - If the router's CAM is full it gives no ack; req_o stays high indefinitely, which causes the router to retry.
  - tx_ready_o=0 in TX_REQ and TX_RELEASE.
  - Latency: accept-to-req is 1 cycle.
- RX FSM states: RX_IDLE, RX_ACK.
  - RX_IDLE: ack_o=0. If req_i && !fifo_full: push flit_i and go to RX_ACK. If full: ack withheld; the router stalls in its local-delivery state.
  - RX_ACK: ack_o=1; on req_i=0, go to RX_IDLE. This serves both the router's 4-phase local delivery and its all-ports ack collection.
  - Flit data is sampled in the cycle the push decision is made.
- FIFO:
  - rx_valid_o = count != 0.
  - Pop on rx_valid_o && rx_ready_i.
  - Full is evaluated on the registered count: a pop in the same cycle does not enable a push while full. The push takes place the following cycle.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - Pointers wrap modulo RX_FIFO_DEPTH.
  - Pop while empty is ignored.
- Reset mid-operation clears all state immediately. Any partially handshaken flit is lost; the system-level reset covers the router.

Optional Feature:
- Macro: BRLITE_NI_STATS_EN.
- With the macro defined, three extra outputs:
  - tx_count_o [31:0]: increments when the TX FSM leaves TX_REQ on ack.
  - rx_count_o [31:0]: increments on each FIFO push.
  - rx_stall_o [31:0]: increments every cycle req_i=1 while RX is in RX_IDLE and the FIFO is full.
  - All three wrap, reset to 0.
- Without the macro: these ports and their counters do not exist.

Decomposition:
- Add to BrLitePkg (if absent): br_svc_t, br_payload_t, br_id_t as named typedefs of the br_data_t fields.
- br_data_t, BR_SVC_*, BR_LOCAL are used from BrLitePkg unchanged.
- One sub-module: br_lite_fifo, a parameterised synchronous FIFO of br_data_t exposing full, empty, push, pop, and head.

Test Plan:
- Reset → req_o=0, ack_o=0, rx_valid_o=0; with local_busy_i=0, tx_ready_o=1.
- Send ALL, payload 0xA5, with ADDRESS=16'h0102; ack_i raised 3 cycles after req → flit_o.source=0x0102, id=0; req high exactly until ack. A second send carries id=1.
- local_busy_i=1 with tx_valid_i=1 for 10 cycles → tx_ready_o=0 and req_o never rises. Deassert busy → accepted next cycle.
- RX_FIFO_DEPTH=4, rx_ready_i=0, router offers 5 flits:
  - first 4 are acked and stored in order;
  - 5th req held with ack_o=0;
  - one pop → 5th acked within 2 cycles.
- After 2^W accepted sends (W = id width) → next flit id=0.
- Assert rst_ni low while in TX_REQ → req_o=0 immediately, id counter=0, FIFO empty after release.

Source files
------------

// File: rtl/br_lite_ni_pkg.sv
// BrLite shared types: flit layout, service codes, local port index, NI FSM states.
package BrLitePkg;

  localparam int unsigned BR_LOCAL = 4;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2,
    BR_SVC_MON   = 2'd3
  } br_svc_t;

  typedef logic [15:0] br_addr_t;
  typedef logic [7:0]  br_payload_t;
  typedef logic [4:0]  br_id_t;

  typedef struct packed {
    br_addr_t    source;
    br_addr_t    target;
    br_svc_t     service;
    br_payload_t payload;
    br_id_t      id;
  } br_data_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_RELEASE
  } br_ni_tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } br_ni_rx_state_t;

  // Only broadcast and targeted requests become router traffic from a PE.
  function automatic logic br_svc_injects(input br_svc_t svc);
    return (svc == BR_SVC_ALL) || (svc == BR_SVC_TGT);
  endfunction

endpackage

// File: rtl/br_lite_fifo.sv
// Synchronous FIFO of br_data_t; DEPTH must be a power of two >= 2.
module br_lite_fifo
  import BrLitePkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  br_data_t data_i,
  output br_data_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  br_data_t          mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_en, pop_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_en) wr_d = wr_q + PW'(1);
    if (pop_en)  rd_d = rd_q + PW'(1);
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/br_lite_ni.sv
// BrLite network interface: PE valid/ready <-> router local-port 4-phase req/ack.
// Define BRLITE_NI_STATS_EN to add tx/rx/stall event counters.
module br_lite_ni
  import BrLitePkg::*;
#(
  parameter logic [15:0] ADDRESS       = 16'h0000,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        local_busy_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  br_svc_t     tx_service_i,
  input  logic [15:0] tx_target_i,
  input  br_payload_t tx_payload_i,
  output br_data_t    flit_o,
  output logic        req_o,
  input  logic        ack_i,
  input  br_data_t    flit_i,
  input  logic        req_i,
  output logic        ack_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output br_data_t    rx_data_o
`ifdef BRLITE_NI_STATS_EN
  ,
  output logic [31:0] tx_count_o,
  output logic [31:0] rx_count_o,
  output logic [31:0] rx_stall_o
`endif
);

  br_ni_tx_state_t tx_state_q, tx_state_d;
  br_ni_rx_state_t rx_state_q, rx_state_d;
  br_data_t        flit_q, flit_d;
  br_id_t          id_q, id_d;
  logic            push, pop, fifo_full, fifo_empty;

  // TX: unsupported services are consumed in IDLE without touching the id counter.
  always_comb begin
    tx_state_d = tx_state_q;
    flit_d     = flit_q;
    id_d       = id_q;
    tx_ready_o = 1'b0;
    req_o      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_ready_o = !local_busy_i;
        if (tx_valid_i && !local_busy_i && br_svc_injects(tx_service_i)) begin
          flit_d     = '{source:  ADDRESS,
                         target:  tx_target_i,
                         service: tx_service_i,
                         payload: tx_payload_i,
                         id:      id_q};
          id_d       = id_q + br_id_t'(1);
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        req_o = 1'b1;
        if (ack_i) tx_state_d = TX_RELEASE;
      end
      TX_RELEASE: begin
        if (!ack_i) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX: full is the registered FIFO state, so a same-cycle pop never admits a push.
  always_comb begin
    rx_state_d = rx_state_q;
    push       = 1'b0;
    ack_o      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (req_i && !fifo_full) begin
          push       = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        ack_o = 1'b1;
        if (!req_i) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      flit_q     <= '0;
      id_q       <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      flit_q     <= flit_d;
      id_q       <= id_d;
    end
  end

  assign flit_o     = flit_q;
  assign rx_valid_o = !fifo_empty;
  assign pop        = rx_valid_o && rx_ready_i;

  br_lite_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (flit_i),
    .head_o  (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef BRLITE_NI_STATS_EN
  logic tx_done, rx_stall;
  logic [31:0] tx_cnt_q, rx_cnt_q, stall_cnt_q;

  assign tx_done  = (tx_state_q == TX_REQ) && ack_i;
  assign rx_stall = (rx_state_q == RX_IDLE) && req_i && fifo_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (tx_done)  tx_cnt_q    <= tx_cnt_q + 32'd1;
      if (push)     rx_cnt_q    <= rx_cnt_q + 32'd1;
      if (rx_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign tx_count_o = tx_cnt_q;
  assign rx_count_o = rx_cnt_q;
  assign rx_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_br_lite_ni.sv
// Self-checking bench for br_lite_ni: directed table, corner sequences, random traffic vs queue model.
module tb_br_lite_ni;
  import BrLitePkg::*;

  localparam logic [15:0] ADDR  = 16'h0102;
  localparam int unsigned DEPTH = 4;

  logic        clk_i, rst_ni, local_busy_i, tx_valid_i, tx_ready_o;
  br_svc_t     tx_service_i;
  logic [15:0] tx_target_i;
  br_payload_t tx_payload_i;
  br_data_t    flit_o, flit_i, rx_data_o;
  logic        req_o, ack_i, req_i, ack_o, rx_valid_o, rx_ready_i;

  br_lite_ni #(
    .ADDRESS       (ADDR),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .local_busy_i (local_busy_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_service_i (tx_service_i),
    .tx_target_i  (tx_target_i),
    .tx_payload_i (tx_payload_i),
    .flit_o       (flit_o),
    .req_o        (req_o),
    .ack_i        (ack_i),
    .flit_i       (flit_i),
    .req_i        (req_i),
    .ack_o        (ack_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned vectors;
  int unsigned miscompares;
  br_id_t      model_id;
  br_data_t    rxq[$];

  typedef struct {
    br_svc_t     svc;
    logic [15:0] tgt;
    br_payload_t pl;
    int unsigned dly;
    logic        inj;
  } tx_vec_t;

  tx_vec_t tv[6];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input br_svc_t svc, input logic [15:0] tgt, input br_payload_t pl,
                      input int unsigned dly, input logic inj, input string tag);
    br_data_t    exp;
    int unsigned n;
    logic        held;
    tx_service_i = svc;
    tx_target_i  = tgt;
    tx_payload_i = pl;
    tx_valid_i   = 1'b1;
    n = 0;
    while (tx_ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, tx_ready_o, 1);
    tick();
    tx_valid_i = 1'b0;
    chk({tag, "_req_rise"}, req_o, inj);
    if (!inj) begin
      chk({tag, "_stay_idle"}, tx_ready_o, 1);
      return;
    end
    exp = '{source: ADDR, target: tgt, service: svc, payload: pl, id: model_id};
    model_id = model_id + br_id_t'(1);
    chk({tag, "_flit"}, flit_o, exp);
    held = 1'b1;
    for (int unsigned k = 0; k < dly; k++) begin
      tick();
      held = held & (req_o === 1'b1) & (flit_o === exp);
    end
    chk({tag, "_req_held"}, held, 1);
    ack_i = 1'b1;
    tick();
    chk({tag, "_req_drop"}, req_o, 0);
    chk({tag, "_busy_release"}, tx_ready_o, 0);
    ack_i = 1'b0;
    tick();
    chk({tag, "_back_idle"}, tx_ready_o, 1);
  endtask

  task automatic rx_offer(input br_data_t f, input string tag);
    int unsigned n;
    flit_i = f;
    req_i  = 1'b1;
    n = 0;
    while (ack_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_ack"}, ack_o, 1);
    rxq.push_back(f);
    req_i = 1'b0;
    n = 0;
    while (ack_o !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_ack_drop"}, ack_o, 0);
  endtask

  task automatic rx_stall_probe(input br_data_t f, input string tag);
    logic seen;
    flit_i = f;
    req_i  = 1'b1;
    seen   = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      seen = seen | ack_o;
    end
    chk({tag, "_withheld"}, seen, 0);
    req_i = 1'b0;
    tick();
  endtask

  task automatic rx_pop(input string tag);
    chk({tag, "_valid"}, rx_valid_o, rxq.size() != 0);
    if (rxq.size() != 0) chk({tag, "_data"}, rx_data_o, rxq[0]);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    if (rxq.size() != 0) void'(rxq.pop_front());
  endtask

  function automatic br_data_t rand_flit();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return br_data_t'(r[$bits(br_data_t)-1:0]);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    br_data_t    f5;
    logic        ok;
    int unsigned n;
    br_svc_t     svc;

    vectors      = 0;
    miscompares  = 0;
    model_id     = '0;
    rst_ni       = 1'b0;
    local_busy_i = 1'b0;
    tx_valid_i   = 1'b0;
    tx_service_i = BR_SVC_ALL;
    tx_target_i  = '0;
    tx_payload_i = '0;
    ack_i        = 1'b0;
    flit_i       = '0;
    req_i        = 1'b0;
    rx_ready_i   = 1'b0;

    tv[0] = '{BR_SVC_ALL,   16'h0000, 8'hA5, 3, 1'b1};
    tv[1] = '{BR_SVC_TGT,   16'h0304, 8'h5A, 0, 1'b1};
    tv[2] = '{BR_SVC_CLEAR, 16'hFFFF, 8'h11, 1, 1'b0};
    tv[3] = '{BR_SVC_MON,   16'h1234, 8'h22, 0, 1'b0};
    tv[4] = '{BR_SVC_TGT,   16'h0001, 8'hFF, 1, 1'b1};
    tv[5] = '{BR_SVC_ALL,   16'hBEEF, 8'h00, 2, 1'b1};

    repeat (3) tick();
    chk("rst_req", req_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_flit", flit_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("rst_tx_ready", tx_ready_o, 1);

    for (int i = 0; i < 6; i++)
      send(tv[i].svc, tv[i].tgt, tv[i].pl, tv[i].dly, tv[i].inj, $sformatf("tbl%0d", i));

    // local_busy holds off acceptance; release makes the pending request go next cycle
    local_busy_i = 1'b1;
    tx_valid_i   = 1'b1;
    tx_service_i = BR_SVC_ALL;
    tx_payload_i = 8'h3C;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ok = ok & (tx_ready_o === 1'b0) & (req_o === 1'b0);
    end
    chk("busy_block", ok, 1);
    local_busy_i = 1'b0;
    #1;
    chk("busy_release_ready", tx_ready_o, 1);
    send(BR_SVC_ALL, 16'h0000, 8'h3C, 1, 1'b1, "busy_send");

    // full id wrap: model counter crosses 2^5
    for (int i = 0; i < 33; i++)
      send(BR_SVC_TGT, 16'(i), 8'(i * 7), 0, 1'b1, $sformatf("wrap%0d", i));

    // RX fill, stall on full, unstall after one pop
    for (int i = 0; i < 4; i++) rx_offer(rand_flit(), $sformatf("fill%0d", i));
    chk("fill_valid", rx_valid_o, 1);
    f5     = rand_flit();
    flit_i = f5;
    req_i  = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ok = ok | ack_o;
    end
    chk("full_ack_withheld", ok, 0);
    chk("full_head", rx_data_o, rxq[0]);
    rx_ready_i = 1'b1;
    tick();
    rx_ready_i = 1'b0;
    void'(rxq.pop_front());
    n = 0;
    while (ack_o !== 1'b1 && n < 2) begin
      tick();
      n++;
    end
    chk("unstall_ack", ack_o, 1);
    rxq.push_back(f5);
    req_i = 1'b0;
    tick();
    chk("unstall_ack_drop", ack_o, 0);
    for (int i = 0; i < 4; i++) rx_pop($sformatf("drain%0d", i));
    rx_pop("empty_pop");
    chk("empty_after_drain", rx_valid_o, 0);

    // randomized traffic against the queue/counter model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          svc = br_svc_t'($urandom_range(0, 3));
          send(svc, 16'($urandom()), 8'($urandom()), $urandom_range(0, 3),
               (svc == BR_SVC_ALL) || (svc == BR_SVC_TGT), $sformatf("rnd_tx%0d", i));
        end
        1: begin
          if (rxq.size() < DEPTH) rx_offer(rand_flit(), $sformatf("rnd_rx%0d", i));
          else rx_stall_probe(rand_flit(), $sformatf("rnd_stall%0d", i));
        end
        default: rx_pop($sformatf("rnd_pop%0d", i));
      endcase
    end

    // reset while req is outstanding
    if (rxq.size() < DEPTH) rx_offer(rand_flit(), "pre_rst_rx");
    tx_service_i = BR_SVC_TGT;
    tx_target_i  = 16'h00AA;
    tx_payload_i = 8'h77;
    tx_valid_i   = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    chk("pre_rst_req", req_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", req_o, 0);
    chk("mid_rst_rx_valid", rx_valid_o, 0);
    chk("mid_rst_flit", flit_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    rxq.delete();
    model_id = '0;
    tick();
    chk("post_rst_rx_valid", rx_valid_o, 0);
    chk("post_rst_req", req_o, 0);
    send(BR_SVC_ALL, 16'h0000, 8'h99, 1, 1'b1, "post_rst_send");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
